// File: rtl/pov_pkg.sv
// Shared constants, FSM state type and frame slicing helper for the POV display sequencer.
package pov_pkg;

  localparam int unsigned NCHARS        = 11;
  localparam int unsigned CHAR_W        = 7;
  localparam int unsigned COLS_PER_CHAR = 6;
  localparam int unsigned TOTAL_COLS    = NCHARS * COLS_PER_CHAR;
  localparam int unsigned FRAME_W       = NCHARS * CHAR_W;
  localparam int unsigned CHAR_IDX_W    = $clog2(NCHARS);
  localparam int unsigned COL_IDX_W     = $clog2(COLS_PER_CHAR);
  localparam int unsigned PS_W          = $clog2(TOTAL_COLS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DISPLAY = 2'd2
  } state_t;

  // Char 0 sits in the MSBs of the frame, char NCHARS-1 in the LSBs.
  function automatic logic [CHAR_W-1:0] char_at(input logic [FRAME_W-1:0]    frame,
                                                input logic [CHAR_IDX_W-1:0] i);
    return CHAR_W'(frame >> (CHAR_W * (NCHARS - 1 - 32'(i))));
  endfunction

endpackage

// File: rtl/pov_period_meter.sv
// Revolution period meter: counts clocks/TOTAL_COLS between index pulses and
// holds the per-column slot length. The first index after reset or after a
// timeout only starts a measurement, so no bogus short period is judged.
module pov_period_meter
  import pov_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_index,
  output logic [PERIOD_W-1:0] o_col_period,
  output logic [PERIOD_W-1:0] o_period_next_c,
  output logic                o_timeout_c,
  output logic                o_overspeed
);

  logic [PS_W-1:0]     r_ps;
  logic [PERIOD_W-1:0] r_meas;
  logic [PERIOD_W-1:0] r_col_period;
  logic                r_armed;
  logic                r_overspeed;

  logic                w_wrap;
  logic                w_sat;
  logic                w_judge;
  logic                w_ok;
  logic [PERIOD_W-1:0] w_meas_inc;

  // Measurement including the index cycle itself, and the period it would load.
  always_comb begin
    w_wrap     = (r_ps == PS_W'(TOTAL_COLS - 1));
    w_sat      = &r_meas;
    w_meas_inc = r_meas;
    if (w_wrap && !w_sat) w_meas_inc = r_meas + PERIOD_W'(1);
    w_judge         = i_index && r_armed && !w_sat;
    w_ok            = (w_meas_inc >= PERIOD_W'(MIN_PERIOD));
    o_period_next_c = r_col_period;
    if (w_judge && w_ok) o_period_next_c = w_meas_inc;
  end

  // Prescaler, saturating measurement, period load and sticky overspeed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps         <= '0;
      r_meas       <= '0;
      r_col_period <= '0;
      r_armed      <= 1'b0;
      r_overspeed  <= 1'b0;
    end else if (i_index) begin
      r_ps         <= '0;
      r_meas       <= '0;
      r_armed      <= 1'b1;
      r_col_period <= o_period_next_c;
      if (w_judge && !w_ok) r_overspeed <= 1'b1;
    end else begin
      r_ps   <= w_wrap ? '0 : r_ps + PS_W'(1);
      r_meas <= w_meas_inc;
      if (w_sat) r_armed <= 1'b0;
    end
  end

  assign o_col_period = r_col_period;
  assign o_timeout_c  = w_sat;
  assign o_overspeed  = r_overspeed;

endmodule

// File: rtl/pov_scan_ctrl.sv
// POV display sequencer: double-buffers the entry string, measures the rotor
// and steps char/column addresses to the font ROM one slot per column.
// Build option: define POV_MIRROR_EN to scan chars and columns in reverse.
module pov_scan_ctrl
  import pov_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FRAME_W-1:0]   i_string,
  input  logic                 i_complete,
  input  logic                 i_change,
  input  logic                 i_index,
  output logic [CHAR_W-1:0]    o_char_code,
  output logic [COL_IDX_W-1:0] o_col_idx,
  output logic                 o_col_strobe,
  output logic                 o_blank,
  output logic                 o_overspeed
);

  state_t                r_state, w_state_n;
  logic [FRAME_W-1:0]    r_pend, w_pend_n;
  logic                  r_pend_valid, w_pend_valid_n;
  logic [FRAME_W-1:0]    r_frame, w_frame_n;
  logic                  r_frame_valid, w_frame_valid_n;
  logic [CHAR_IDX_W-1:0] r_char, w_char_n;
  logic [COL_IDX_W-1:0]  r_cidx, w_cidx_n;
  logic                  r_done, w_done_n;
  logic [PERIOD_W-1:0]   r_slot, w_slot_n;
  logic [CHAR_W-1:0]     r_char_code;
  logic [COL_IDX_W-1:0]  r_col_idx;
  logic                  r_strobe, w_strobe_n;
  logic                  r_blank, w_blank_n;
  logic                  w_start;
  logic [CHAR_IDX_W-1:0] w_out_char;
  logic [COL_IDX_W-1:0]  w_out_col;

  logic [PERIOD_W-1:0]   w_col_period;
  logic [PERIOD_W-1:0]   w_period_next;
  logic                  w_timeout;

  pov_period_meter #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_meter (
    .clk             (clk),
    .reset           (reset),
    .i_index         (i_index),
    .o_col_period    (w_col_period),
    .o_period_next_c (w_period_next),
    .o_timeout_c     (w_timeout),
    .o_overspeed     (o_overspeed)
  );

  // Next-state: buffers, FSM, slot timer and column stepping.
  always_comb begin
    w_state_n       = r_state;
    w_pend_n        = r_pend;
    w_pend_valid_n  = r_pend_valid;
    w_frame_n       = r_frame;
    w_frame_valid_n = r_frame_valid;
    w_char_n        = r_char;
    w_cidx_n        = r_cidx;
    w_done_n        = r_done;
    w_slot_n        = r_slot;
    w_strobe_n      = 1'b0;
    w_blank_n       = 1'b1;
    w_start         = 1'b0;

    // Index moves the old pending string; a same-cycle capture waits a revolution.
    if (i_index && r_pend_valid) begin
      w_frame_n       = r_pend;
      w_frame_valid_n = 1'b1;
      w_pend_valid_n  = 1'b0;
    end
    if (i_complete || i_change) begin
      w_pend_n       = i_string;
      w_pend_valid_n = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (i_index) w_state_n = MEASURE;
      end
      MEASURE: begin
        if (i_index && w_frame_valid_n && (w_period_next != '0)) begin
          w_state_n = DISPLAY;
          w_start   = 1'b1;
        end
      end
      DISPLAY: begin
        if (i_index) begin
          w_start = 1'b1;
        end else if (!r_done) begin
          w_blank_n = 1'b0;
          if (r_slot == '0) begin
            w_slot_n = w_col_period - PERIOD_W'(1);
            if (r_cidx == COL_IDX_W'(COLS_PER_CHAR - 1)) begin
              w_cidx_n = '0;
              if (r_char == CHAR_IDX_W'(NCHARS - 1)) begin
                w_done_n  = 1'b1;
                w_blank_n = 1'b1;
              end else begin
                w_char_n   = r_char + CHAR_IDX_W'(1);
                w_strobe_n = 1'b1;
              end
            end else begin
              w_cidx_n   = r_cidx + COL_IDX_W'(1);
              w_strobe_n = 1'b1;
            end
          end else begin
            w_slot_n = r_slot - PERIOD_W'(1);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_start) begin
      w_char_n   = '0;
      w_cidx_n   = '0;
      w_done_n   = 1'b0;
      w_slot_n   = w_period_next - PERIOD_W'(1);
      w_strobe_n = 1'b1;
      w_blank_n  = 1'b0;
    end

    // A saturated meter means the rotor stopped; only an index in IDLE gets past it.
    if (w_timeout && !((r_state == IDLE) && i_index)) begin
      w_state_n  = IDLE;
      w_strobe_n = 1'b0;
      w_blank_n  = 1'b1;
    end

`ifdef POV_MIRROR_EN
    w_out_char = CHAR_IDX_W'(NCHARS - 1) - w_char_n;
    w_out_col  = COL_IDX_W'(COLS_PER_CHAR - 1) - w_cidx_n;
`else
    w_out_char = w_char_n;
    w_out_col  = w_cidx_n;
`endif
  end

  // State and output registers; ROM address only changes with a new column.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_char        <= '0;
      r_cidx        <= '0;
      r_done        <= 1'b0;
      r_slot        <= '0;
      r_char_code   <= '0;
      r_col_idx     <= '0;
      r_strobe      <= 1'b0;
      r_blank       <= 1'b1;
    end else begin
      r_state       <= w_state_n;
      r_pend        <= w_pend_n;
      r_pend_valid  <= w_pend_valid_n;
      r_frame       <= w_frame_n;
      r_frame_valid <= w_frame_valid_n;
      r_char        <= w_char_n;
      r_cidx        <= w_cidx_n;
      r_done        <= w_done_n;
      r_slot        <= w_slot_n;
      r_strobe      <= w_strobe_n;
      r_blank       <= w_blank_n;
      if (w_strobe_n) begin
        r_char_code <= char_at(w_frame_n, w_out_char);
        r_col_idx   <= w_out_col;
      end
    end
  end

  assign o_char_code  = r_char_code;
  assign o_col_idx    = r_col_idx;
  assign o_col_strobe = r_strobe;
  assign o_blank      = r_blank;

endmodule

// File: tb/tb_pov_scan_ctrl.sv
// Scoreboard bench for pov_scan_ctrl. An 8-bit period width keeps the meter
// timeout reachable in a short run; col_period of 100 still fits.
module tb_pov_scan_ctrl;
  import pov_pkg::*;

  localparam int unsigned PW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [FRAME_W-1:0]   i_string;
  logic                 i_complete;
  logic                 i_change;
  logic                 i_index;
  logic [CHAR_W-1:0]    o_char_code;
  logic [COL_IDX_W-1:0] o_col_idx;
  logic                 o_col_strobe;
  logic                 o_blank;
  logic                 o_overspeed;

  pov_scan_ctrl #(.PERIOD_W(PW), .MIN_PERIOD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_string     (i_string),
    .i_complete   (i_complete),
    .i_change     (i_change),
    .i_index      (i_index),
    .o_char_code  (o_char_code),
    .o_col_idx    (o_col_idx),
    .o_col_strobe (o_col_strobe),
    .o_blank      (o_blank),
    .o_overspeed  (o_overspeed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   at;
    logic [CHAR_W-1:0]    code;
    logic [COL_IDX_W-1:0] col;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   last_idx = 0;

  logic [FRAME_W-1:0] s_hello, s_bye, s_abc;

  function automatic logic [FRAME_W-1:0] pack_str(input string s);
    logic [FRAME_W-1:0] f;
    byte b;
    f = '0;
    for (int i = 0; i < int'(NCHARS); i++) begin
      b = s[i];
      f[(int'(NCHARS) - 1 - i) * int'(CHAR_W) +: CHAR_W] = b[6:0];
    end
    return f;
  endfunction

  // Advance one cycle and retire scoreboard entries against observed strobes.
  task automatic step_cycle();
    exp_t e;
    @(negedge clk);
    if (o_col_strobe === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected cyc=%0d code=%h col=%0d", cyc, o_char_code, o_col_idx);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.at || o_char_code !== e.code || o_col_idx !== e.col || o_blank !== 1'b0) begin
          bad++;
          $display("FAIL strobe cyc=%0d/%0d code=%h/%h col=%0d/%0d blank=%b/0 (got/exp)",
                   cyc, e.at, o_char_code, e.code, o_col_idx, e.col, o_blank);
        end
      end
    end
    while (sbq.size() > 0 && sbq[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL strobe_missing cyc=%0d expected_at=%0d code=%h", cyc, sbq[0].at, sbq[0].code);
      e = sbq.pop_front();
    end
  endtask

  // One revolution: index pulse, expected strobes pushed, optional capture mid-way.
  // cap_at 0 = complete in the index cycle, >0 = change at that offset; tail 2 = no blank check.
  task automatic rev(input int gap, input int per, input bit show, input logic [FRAME_W-1:0] frm,
                     input int cap_at, input logic [FRAME_W-1:0] cap_val, input int tail);
    int   n, ch, ci, idx_cyc;
    exp_t e;
    idx_cyc  = cyc;
    last_idx = cyc;
    if (show) begin
      n = (gap - 1) / per + 1;
      if (n > int'(TOTAL_COLS)) n = int'(TOTAL_COLS);
      for (int k = 0; k < n; k++) begin
        ch = k / int'(COLS_PER_CHAR);
        ci = k % int'(COLS_PER_CHAR);
`ifdef POV_MIRROR_EN
        ch = int'(NCHARS) - 1 - ch;
        ci = int'(COLS_PER_CHAR) - 1 - ci;
`endif
        e.at   = idx_cyc + 1 + per * k;
        e.code = frm[(int'(NCHARS) - 1 - ch) * int'(CHAR_W) +: CHAR_W];
        e.col  = COL_IDX_W'(ci);
        sbq.push_back(e);
      end
    end
    i_index = 1'b1;
    if (cap_at == 0) begin
      i_string   = cap_val;
      i_complete = 1'b1;
    end
    step_cycle();
    i_index    = 1'b0;
    i_complete = 1'b0;
    while (cyc < idx_cyc + gap) begin
      if (cap_at > 0 && cyc == idx_cyc + cap_at) begin
        i_string = cap_val;
        i_change = 1'b1;
      end
      step_cycle();
      i_change = 1'b0;
    end
    if (tail != 2) begin
      total++;
      if (o_blank !== tail[0]) begin
        bad++;
        $display("FAIL rev_tail_blank cyc=%0d got=%b exp=%b", cyc, o_blank, tail[0]);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    i_string   = '0;
    i_complete = 1'b0;
    i_change   = 1'b0;
    i_index    = 1'b0;
    repeat (3) step_cycle();
    total += 5;
    if (o_blank !== 1'b1)      begin bad++; $display("FAIL reset_blank got=%b exp=1", o_blank); end
    if (o_col_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", o_col_strobe); end
    if (o_overspeed !== 1'b0)  begin bad++; $display("FAIL reset_overspeed got=%b exp=0", o_overspeed); end
    if (o_char_code !== '0)    begin bad++; $display("FAIL reset_char_code got=%h exp=0", o_char_code); end
    if (o_col_idx !== '0)      begin bad++; $display("FAIL reset_col_idx got=%0d exp=0", o_col_idx); end
    reset = 1'b0;
    step_cycle();
    total++;
    if (dut.r_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
  endtask

  task automatic test_no_string();
    rev(6600, 100, 1'b0, '0, -1, '0, 1);
    rev(6600, 100, 1'b0, '0, -1, '0, 1);
    total += 3;
    if (dut.u_meter.o_col_period !== PW'(100)) begin
      bad++; $display("FAIL nostr_period got=%0d exp=100", dut.u_meter.o_col_period);
    end
    if (dut.r_state !== MEASURE) begin bad++; $display("FAIL nostr_state got=%0d exp=%0d", dut.r_state, MEASURE); end
    if (o_overspeed !== 1'b0)    begin bad++; $display("FAIL nostr_overspeed got=%b exp=0", o_overspeed); end
  endtask

  task automatic test_hello();
    i_string   = s_hello;
    i_complete = 1'b1;
    step_cycle();
    i_complete = 1'b0;
    rev(6640, 100, 1'b1, s_hello, -1, '0, 1);
  endtask

  task automatic test_change();
    rev(6600, 100, 1'b1, s_hello, 3000, s_bye, 0);
    rev(6600, 100, 1'b1, s_bye, 0, s_abc, 0);
    rev(6600, 100, 1'b1, s_abc, -1, '0, 0);
  endtask

  task automatic test_overspeed();
    rev(132, 100, 1'b1, s_abc, -1, '0, 2);
    total++;
    if (o_overspeed !== 1'b0) begin bad++; $display("FAIL ovs_before got=%b exp=0", o_overspeed); end
    rev(6600, 100, 1'b1, s_abc, -1, '0, 0);
    total += 2;
    if (o_overspeed !== 1'b1) begin bad++; $display("FAIL ovs_after got=%b exp=1", o_overspeed); end
    if (dut.u_meter.o_col_period !== PW'(100)) begin
      bad++; $display("FAIL ovs_period got=%0d exp=100", dut.u_meter.o_col_period);
    end
  endtask

  task automatic test_timeout();
    int n;
    total++;
    if (dut.r_state !== DISPLAY) begin bad++; $display("FAIL tmo_early_state got=%0d exp=%0d", dut.r_state, DISPLAY); end
    n = 0;
    while (dut.r_state !== IDLE && n < 20000) begin
      step_cycle();
      n++;
    end
    total += 2;
    if (cyc - last_idx !== 2 + int'(TOTAL_COLS) * ((1 << PW) - 1)) begin
      bad++; $display("FAIL tmo_time got=%0d exp=%0d", cyc - last_idx, 2 + int'(TOTAL_COLS) * ((1 << PW) - 1));
    end
    if (o_blank !== 1'b1) begin bad++; $display("FAIL tmo_blank got=%b exp=1", o_blank); end
    rev(6600, 100, 1'b0, '0, -1, '0, 1);
    total++;
    if (dut.r_state !== MEASURE) begin bad++; $display("FAIL tmo_resume_state got=%0d exp=%0d", dut.r_state, MEASURE); end
    rev(6600, 100, 1'b1, s_abc, -1, '0, 0);
  endtask

  task automatic test_truncate();
    rev(3300, 100, 1'b1, s_abc, -1, '0, 2);
    rev(3400, 50, 1'b1, s_abc, -1, '0, 1);
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sbq.size()); end
  endtask

  initial begin
    s_hello = pack_str("HELLO WORLD");
    s_bye   = pack_str("GOODBYE ALL");
    s_abc   = pack_str("ABCDEFGHIJK");
    test_reset();
    test_no_string();
    test_hello();
    test_change();
    test_overspeed();
    test_timeout();
    test_truncate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
